instr_queue: RTL

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_if.sv | 37 +++
 rtl/instr_queue.sv | 76 +++++++
 2 files changed

// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue bus: two fetch slots in, two head entries out.
interface instr_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          valid_f_0;
  logic          valid_f_1;
  logic [31:0]   instr_f_0;
  logic [31:0]   instr_f_1;
  logic [31:0]   pc_f_0;
  logic [31:0]   pc_f_1;
  logic          flush_d;
  logic [1:0]    take_d;
  logic          stall_f;
  logic          valid_d_0;
  logic          valid_d_1;
  logic [31:0]   instr_d_0;
  logic [31:0]   instr_d_1;
  logic [31:0]   pc_d_0;
  logic [31:0]   pc_d_1;
  logic [CW-1:0] count_q;

  modport master (
    output valid_f_0, valid_f_1, instr_f_0, instr_f_1, pc_f_0, pc_f_1,
    output flush_d, take_d,
    input  stall_f, valid_d_0, valid_d_1, instr_d_0, instr_d_1,
    input  pc_d_0, pc_d_1, count_q
  );

  modport slave (
    input  valid_f_0, valid_f_1, instr_f_0, instr_f_1, pc_f_0, pc_f_1,
    input  flush_d, take_d,
    output stall_f, valid_d_0, valid_d_1, instr_d_0, instr_d_1,
    output pc_d_0, pc_d_1, count_q
  );
endinterface

// File: rtl/instr_queue.sv
// Dual-issue instruction queue: circular buffer accepting up to two fetched
// instructions and presenting up to two head entries to decode each cycle.
module instr_queue #(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  instr_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [AW-1:0] wr_ptr_1;
  logic [AW-1:0] rd_ptr_1;

  // Pops are the requested take (3 clamps to 2), never more than what is held.
  function automatic logic [CW-1:0] sat_pop(input logic [1:0] take,
                                            input logic [CW-1:0] cnt);
    logic [CW-1:0] req;
    req = (take == 2'd3) ? CW'(2) : CW'(take);
    return (req > cnt) ? cnt : req;
  endfunction

  assign q.stall_f = (count > CW'(DEPTH - 2));
  assign accept    = !q.stall_f && !q.flush_d;
  assign push_n    = (accept && q.valid_f_0) ? (q.valid_f_1 ? CW'(2) : CW'(1)) : '0;
  assign pop_n     = sat_pop(q.take_d, count);
  assign wr_ptr_1  = wr_ptr + AW'(1);
  assign rd_ptr_1  = rd_ptr + AW'(1);

  // Control state: pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush_d) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + push_n - pop_n;
    end
  end

  // Storage: no reset, outputs are masked by occupancy
  always_ff @(posedge clk) begin
    if (accept && q.valid_f_0) begin
      instr_mem[wr_ptr] <= q.instr_f_0;
      pc_mem[wr_ptr]    <= q.pc_f_0;
      if (q.valid_f_1) begin
        instr_mem[wr_ptr_1] <= q.instr_f_1;
        pc_mem[wr_ptr_1]    <= q.pc_f_1;
      end
    end
  end

  assign q.valid_d_0 = (count >= CW'(1));
  assign q.valid_d_1 = (count >= CW'(2));
  assign q.instr_d_0 = q.valid_d_0 ? instr_mem[rd_ptr]   : '0;
  assign q.pc_d_0    = q.valid_d_0 ? pc_mem[rd_ptr]      : '0;
  assign q.instr_d_1 = q.valid_d_1 ? instr_mem[rd_ptr_1] : '0;
  assign q.pc_d_1    = q.valid_d_1 ? pc_mem[rd_ptr_1]    : '0;
  assign q.count_q   = count;
endmodule
